mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 31 +++
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, load/store port, flush input and byte-wide RAM bus used by mem_ctrl.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        branch_interception;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
               branch_interception, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
               branch_interception, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and load/stores onto a byte-wide RAM with one-cycle read latency,
// assembling little-endian words and issuing one done pulse per completed access.
module mem_ctrl (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          is_if_q, is_if_d;
    logic          is_wr_q, is_wr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_wr_q, ram_wr_d;
    logic [BW-1:0] ram_dout_q, ram_dout_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rbuf_q, rbuf_d;
    logic [DW-1:0] if_inst_q, if_inst_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic [1:0]    cap_idx;
    logic          in_done, if_deliver, load_done;

    function automatic logic [CW-1:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return CW'(1);
            2'd1:    return CW'(2);
            default: return CW'(4);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            is_if_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            is_if_q     <= is_if_d;
            is_wr_q     <= is_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // cnt_q counts edges since the grant; read byte cnt_q-1 arrives on ram_din in that cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        is_if_d     = is_if_q;
        is_wr_d     = is_wr_q;
        ram_addr_d  = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = '0;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        cap_idx     = 2'(cnt_q - CW'(1));

        unique case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    state_d    = bus.mem_we ? MEM_WR : MEM_RD;
                    is_if_d    = 1'b0;
                    is_wr_d    = bus.mem_we;
                    len_d      = len_bytes(bus.mem_len);
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    ram_addr_d = bus.mem_addr;
                    ram_wr_d   = bus.mem_we;
                    ram_dout_d = bus.mem_we ? bus.mem_wdata[BW-1:0] : '0;
                    wdata_d    = bus.mem_wdata >> BW;
                end else if (bus.if_req && !bus.branch_interception) begin
                    state_d    = IF_RD;
                    is_if_d    = 1'b1;
                    is_wr_d    = 1'b0;
                    len_d      = CW'(4);
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    ram_addr_d = bus.if_addr;
                end
            end
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && bus.branch_interception) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) begin
                        rbuf_d[{cap_idx, 3'b000} +: BW] = bus.ram_din;
                    end
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) < len_q) begin
                            ram_addr_d = ram_addr_q + AW'(1);
                        end
                    end
                end
            end
            MEM_WR: begin
                if (cnt_q + CW'(1) == len_q) begin
                    state_d = DONE;
                    cnt_d   = len_q;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    ram_addr_d = ram_addr_q + AW'(1);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[BW-1:0];
                    wdata_d    = wdata_q >> BW;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (is_if_q) begin
                    if (!bus.branch_interception) begin
                        if_inst_d = rbuf_q;
                    end
                end else if (!is_wr_q) begin
                    mem_rdata_d = rbuf_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A flush during the DONE cycle of a fetch suppresses the pulse and keeps the old word visible.
    assign in_done    = (state_q == DONE);
    assign if_deliver = in_done && is_if_q && !bus.branch_interception;
    assign load_done  = in_done && !is_if_q && !is_wr_q;

    assign bus.if_done   = if_deliver;
    assign bus.if_inst   = if_deliver ? rbuf_q : if_inst_q;
    assign bus.mem_done  = in_done && !is_if_q;
    assign bus.mem_rdata = load_done ? rbuf_q : mem_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.ram_dout  = ram_dout_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios and randomized traffic checked against a transaction-level
// memory model (expected bytes, latencies and address sequences computed from the access rules).
`timescale 1ns/1ps
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram     [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [31:0] log_addr[$];
    logic        log_wr[$];
    logic [7:0]  log_dout[$];
    logic [31:0] last_inst  = '0;
    logic [31:0] last_rdata = '0;
    bit          dual_done  = 1'b0;

    int          r_lat;
    logic [31:0] r_data;
    logic        r_post_done;
    logic [31:0] r_post_addr, r_post_inst, r_post_rdata;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
        return w;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    // One clock: sample the RAM bus mid-cycle, then after the edge commit writes and return read data.
    task automatic tick();
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        @(negedge clk);
        a = bus.ram_addr;
        w = bus.ram_wr;
        d = bus.ram_dout;
        @(posedge clk);
        #1;
        if (w) ram[a] = d;
        bus.ram_din = ram_rd(a);
        if (bus.if_done && bus.mem_done) dual_done = 1'b1;
    endtask

    task automatic run_access(input bit is_if, input bit we, input logic [31:0] addr,
                              input logic [1:0] len, input logic [31:0] wdata);
        log_addr.delete();
        log_wr.delete();
        log_dout.delete();
        r_lat  = -1;
        r_data = '0;
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_addr  = addr;
            bus.mem_len   = len;
            bus.mem_wdata = wdata;
        end
        for (int j = 0; j < 16; j++) begin
            tick();
            log_addr.push_back(bus.ram_addr);
            log_wr.push_back(bus.ram_wr);
            log_dout.push_back(bus.ram_dout);
            if (is_if ? bus.if_done : bus.mem_done) begin
                r_lat  = j;
                r_data = is_if ? bus.if_inst : bus.mem_rdata;
                break;
            end
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        tick();
        r_post_done  = bus.if_done | bus.mem_done;
        r_post_addr  = bus.ram_addr;
        r_post_inst  = bus.if_inst;
        r_post_rdata = bus.mem_rdata;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if ({bus.if_done, bus.mem_done, bus.ram_wr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.if_done, bus.mem_done, bus.ram_wr}); end
        n_checks++; if (bus.ram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_ram_addr: got %h expected 0", bus.ram_addr); end
        n_checks++; if (bus.ram_dout !== 8'h0) begin n_fail++; $display("FAIL reset_ram_dout: got %h expected 0", bus.ram_dout); end
        n_checks++; if (bus.if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst: got %h expected 0", bus.if_inst); end
        n_checks++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h expected 0", bus.mem_rdata); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_if_fetch();
        poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        run_access(1'b1, 1'b0, 32'h100, 2'd3, 32'h0);
        n_checks++; if (r_lat !== 5) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 5", r_lat); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (log_addr[k] !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %h expected %h", k, log_addr[k], 32'h100 + 32'(k)); end
        end
        n_checks++; if (r_data !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_inst: got %h expected 00000013", r_data); end
        last_inst = 32'h0000_0013;
        n_checks++; if (r_post_inst !== last_inst) begin n_fail++; $display("FAIL fetch_inst_hold: got %h expected %h", r_post_inst, last_inst); end
        n_checks++; if (r_post_done !== 1'b0) begin n_fail++; $display("FAIL fetch_single_pulse: got %b expected 0", r_post_done); end
    endtask

    task automatic test_conflict();
        int          j_mem, j_if;
        logic [31:0] mem_val, if_val;
        poke(32'h20, 8'hFF);
        for (int k = 0; k < 4; k++) poke(32'h300 + 32'(k), 8'($urandom));
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h20; bus.mem_len = 2'd0;
        j_mem = -1; j_if = -1; mem_val = '0; if_val = '0;
        log_addr.delete();
        for (int j = 0; j < 24; j++) begin
            tick();
            log_addr.push_back(bus.ram_addr);
            if (bus.mem_done) begin j_mem = j; mem_val = bus.mem_rdata; bus.mem_req = 1'b0; end
            if (bus.if_done) begin j_if = j; if_val = bus.if_inst; bus.if_req = 1'b0; break; end
        end
        bus.mem_req = 1'b0; bus.if_req = 1'b0;
        tick();
        n_checks++; if (log_addr[0] !== 32'h20) begin n_fail++; $display("FAIL conflict_mem_first: got %h expected 00000020", log_addr[0]); end
        n_checks++; if (j_mem !== 2) begin n_fail++; $display("FAIL conflict_mem_latency: got %0d expected 2", j_mem); end
        n_checks++; if (mem_val !== 32'h0000_00FF) begin n_fail++; $display("FAIL conflict_mem_rdata: got %h expected 000000ff", mem_val); end
        n_checks++; if (log_addr[j_mem + 2] !== 32'h300) begin n_fail++; $display("FAIL conflict_if_grant: got %h expected 00000300", log_addr[j_mem + 2]); end
        n_checks++; if (j_if !== j_mem + 7) begin n_fail++; $display("FAIL conflict_if_done: got %0d expected %0d", j_if, j_mem + 7); end
        n_checks++; if (if_val !== ref_word(32'h300, 4)) begin n_fail++; $display("FAIL conflict_if_inst: got %h expected %h", if_val, ref_word(32'h300, 4)); end
        last_inst  = ref_word(32'h300, 4);
        last_rdata = 32'h0000_00FF;
    endtask

    task automatic test_store();
        poke(32'h40, 8'h00); poke(32'h41, 8'h00); poke(32'h42, 8'h5A);
        run_access(1'b0, 1'b1, 32'h40, 2'd1, 32'hAABB_CCDD);
        n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", r_lat); end
        n_checks++; if ({log_wr[0], log_wr[1], log_wr[2]} !== 3'b110) begin n_fail++; $display("FAIL store_wr_strobe: got %b expected 110", {log_wr[0], log_wr[1], log_wr[2]}); end
        n_checks++; if ({log_addr[0], log_addr[1]} !== {32'h40, 32'h41}) begin n_fail++; $display("FAIL store_addr: got %h %h expected 40 41", log_addr[0], log_addr[1]); end
        n_checks++; if ({log_dout[0], log_dout[1]} !== 16'hDDCC) begin n_fail++; $display("FAIL store_dout: got %h %h expected dd cc", log_dout[0], log_dout[1]); end
        ref_mem[32'h40] = 8'hDD; ref_mem[32'h41] = 8'hCC;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (ram_rd(32'h40 + 32'(k)) !== ref_rd(32'h40 + 32'(k))) begin n_fail++; $display("FAIL store_ram[%0d]: got %h expected %h", k, ram_rd(32'h40 + 32'(k)), ref_rd(32'h40 + 32'(k))); end
        end
        n_checks++; if (r_post_rdata !== last_rdata) begin n_fail++; $display("FAIL store_rdata_hold: got %h expected %h", r_post_rdata, last_rdata); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) poke(32'h180 + 32'(k), 8'($urandom));
        for (int k = 0; k < 4; k++) poke(32'h200 + 32'(k), 8'($urandom));
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        tick(); tick(); tick();
        bus.branch_interception = 1'b1;
        bus.if_addr = 32'h200;
        #1;
        n_checks++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", bus.if_done); end
        tick();
        bus.branch_interception = 1'b0;
        #1;
        n_checks++; if (bus.ram_addr !== 32'h0) begin n_fail++; $display("FAIL flush_idle_addr: got %h expected 0", bus.ram_addr); end
        n_checks++; if (bus.if_inst !== last_inst) begin n_fail++; $display("FAIL flush_inst_kept: got %h expected %h", bus.if_inst, last_inst); end
        run_access(1'b1, 1'b0, 32'h200, 2'd3, 32'h0);
        n_checks++; if (r_lat !== 5) begin n_fail++; $display("FAIL flush_refetch_latency: got %0d expected 5", r_lat); end
        n_checks++; if (log_addr[0] !== 32'h200) begin n_fail++; $display("FAIL flush_refetch_addr: got %h expected 00000200", log_addr[0]); end
        n_checks++; if (r_data !== ref_word(32'h200, 4)) begin n_fail++; $display("FAIL flush_refetch_inst: got %h expected %h", r_data, ref_word(32'h200, 4)); end
        last_inst = ref_word(32'h200, 4);
        // abort during the completion cycle of a fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        for (int j = 0; j < 6; j++) tick();
        bus.branch_interception = 1'b1;
        bus.if_req = 1'b0;
        #1;
        n_checks++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_abort: got %b expected 0", bus.if_done); end
        n_checks++; if (bus.if_inst !== last_inst) begin n_fail++; $display("FAIL flush_done_inst: got %h expected %h", bus.if_inst, last_inst); end
        tick();
        bus.branch_interception = 1'b0;
        #1;
        n_checks++; if (bus.if_inst !== last_inst) begin n_fail++; $display("FAIL flush_after_inst: got %h expected %h", bus.if_inst, last_inst); end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] wd;
        int          seen;
        wd = $urandom;
        for (int k = 0; k < 4; k++) poke(32'h60 + 32'(k), 8'($urandom));
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h60; bus.mem_len = 2'd3; bus.mem_wdata = wd;
        tick(); tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.if_done, bus.mem_done, bus.ram_wr} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b expected 000", {bus.if_done, bus.mem_done, bus.ram_wr}); end
        n_checks++; if (bus.ram_addr !== 32'h0) begin n_fail++; $display("FAIL midreset_ram_addr: got %h expected 0", bus.ram_addr); end
        n_checks++; if (bus.ram_dout !== 8'h0) begin n_fail++; $display("FAIL midreset_ram_dout: got %h expected 0", bus.ram_dout); end
        n_checks++; if (bus.if_inst !== 32'h0) begin n_fail++; $display("FAIL midreset_if_inst: got %h expected 0", bus.if_inst); end
        n_checks++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_mem_rdata: got %h expected 0", bus.mem_rdata); end
        last_inst = '0; last_rdata = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (bus.mem_done) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", seen); end
        ref_mem[32'h60] = wd[7:0];
        ref_mem[32'h61] = wd[15:8];
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (ram_rd(32'h60 + 32'(k)) !== ref_rd(32'h60 + 32'(k))) begin n_fail++; $display("FAIL midreset_ram[%0d]: got %h expected %h", k, ram_rd(32'h60 + 32'(k)), ref_rd(32'h60 + 32'(k))); end
        end
        run_access(1'b0, 1'b0, 32'h60, 2'd3, 32'h0);
        n_checks++; if (r_lat !== 5) begin n_fail++; $display("FAIL midreset_load_latency: got %0d expected 5", r_lat); end
        n_checks++; if (r_data !== ref_word(32'h60, 4)) begin n_fail++; $display("FAIL midreset_load_data: got %h expected %h", r_data, ref_word(32'h60, 4)); end
        last_rdata = ref_word(32'h60, 4);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) poke(32'hFFFF_FFFE + 32'(k), 8'($urandom));
        run_access(1'b1, 1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (log_addr[k] !== 32'hFFFF_FFFE + 32'(k)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, log_addr[k], 32'hFFFF_FFFE + 32'(k)); end
        end
        n_checks++; if (r_data !== ref_word(32'hFFFF_FFFE, 4)) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", r_data, ref_word(32'hFFFF_FFFE, 4)); end
        last_inst = ref_word(32'hFFFF_FFFE, 4);
    endtask

    task automatic test_random();
        int          kind, n, exp_lat, wr_cnt;
        logic [31:0] addr, wdata, exp_word;
        logic [1:0]  len;
        for (int k = 0; k < 64; k++) poke(32'h1000 + 32'(k), 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            kind  = int'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h1000 + 32'($urandom_range(0, 59));
            len   = (kind == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            wdata = $urandom;
            n     = nbytes(len);
            exp_lat = (kind == 2) ? n : n + 1;
            run_access(kind == 0, kind == 2, addr, len, wdata);
            n_checks++; if (r_lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, r_lat, exp_lat); end
            for (int k = 0; k < n; k++) begin
                n_checks++; if (log_addr[k] !== addr + 32'(k)) begin n_fail++; $display("FAIL rnd%0d_addr[%0d]: got %h expected %h", t, k, log_addr[k], addr + 32'(k)); end
            end
            wr_cnt = 0;
            foreach (log_wr[i]) if (log_wr[i] === 1'b1) wr_cnt++;
            n_checks++; if (wr_cnt !== ((kind == 2) ? n : 0)) begin n_fail++; $display("FAIL rnd%0d_wr_count: got %0d expected %0d", t, wr_cnt, (kind == 2) ? n : 0); end
            n_checks++; if (log_addr[exp_lat] !== 32'h0) begin n_fail++; $display("FAIL rnd%0d_done_addr: got %h expected 0", t, log_addr[exp_lat]); end
            if (kind == 2) begin
                for (int k = 0; k < n; k++) begin
                    n_checks++; if (log_dout[k] !== 8'(wdata >> (8 * k))) begin n_fail++; $display("FAIL rnd%0d_dout[%0d]: got %h expected %h", t, k, log_dout[k], 8'(wdata >> (8 * k))); end
                    ref_mem[addr + 32'(k)] = 8'(wdata >> (8 * k));
                end
                for (int k = 0; k < 4; k++) begin
                    n_checks++; if (ram_rd(addr + 32'(k)) !== ref_rd(addr + 32'(k))) begin n_fail++; $display("FAIL rnd%0d_ram[%0d]: got %h expected %h", t, k, ram_rd(addr + 32'(k)), ref_rd(addr + 32'(k))); end
                end
            end else begin
                exp_word = ref_word(addr, n);
                n_checks++; if (r_data !== exp_word) begin n_fail++; $display("FAIL rnd%0d_data: got %h expected %h", t, r_data, exp_word); end
                if (kind == 0) last_inst = exp_word;
                else           last_rdata = exp_word;
            end
            n_checks++; if (r_post_done !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_single_pulse: got %b expected 0", t, r_post_done); end
            n_checks++; if (r_post_inst !== last_inst) begin n_fail++; $display("FAIL rnd%0d_inst_hold: got %h expected %h", t, r_post_inst, last_inst); end
            n_checks++; if (r_post_rdata !== last_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata_hold: got %h expected %h", t, r_post_rdata, last_rdata); end
        end
        n_checks++; if (dual_done !== 1'b0) begin n_fail++; $display("FAIL dual_done: got %b expected 0", dual_done); end
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_len = '0;
        bus.mem_wdata = '0;
        bus.branch_interception = 1'b0;
        bus.ram_din = '0;
        test_reset();
        test_if_fetch();
        test_conflict();
        test_store();
        test_flush();
        test_reset_mid_store();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
